ysyx_22050078_mem_arbiter: RTL and testbench

YSYX_22050078_MEM_ARBITER -- requirements
Module: ysyx_22050078_mem_arbiter

---
 rtl/ysyx_22050078_mem_arbiter.sv | 115 +++++++++++
 tb/tb_ysyx_22050078_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050078_mem_arbiter.sv
// Two-requester (IFU fetch, LSU load/store) arbiter onto a single memory port, one transaction in flight.
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between requesters; otherwise LSU always wins a tie.
module ysyx_22050078_mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_if_req_valid,
    output logic            o_if_req_ready,
    input  logic [AW-1:0]   i_if_addr,
    output logic            o_if_resp_valid,
    output logic [DW-1:0]   o_if_rdata,
    input  logic            i_ls_req_valid,
    output logic            o_ls_req_ready,
    input  logic [AW-1:0]   i_ls_addr,
    input  logic            i_ls_wen,
    input  logic [DW-1:0]   i_ls_wdata,
    input  logic [DW/8-1:0] i_ls_wmask,
    output logic            o_ls_resp_valid,
    output logic [DW-1:0]   o_ls_rdata,
    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [AW-1:0]   o_mem_addr,
    output logic            o_mem_wen,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wmask,
    input  logic            i_mem_resp_valid,
    input  logic [DW-1:0]   i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state;
    logic   owner_ls;
    logic   tie_to_ls;
    logic   grant_ls;
    logic   grant_if;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ls;

    // A tie goes to whichever requester was not granted last.
    assign tie_to_ls = ~last_ls;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_ls <= 1'b0;
        end else if (grant_ls || grant_if) begin
            last_ls <= grant_ls;
        end
    end
`else
    assign tie_to_ls = 1'b1;
`endif

    assign grant_ls = (state == IDLE) && i_ls_req_valid && (!i_if_req_valid || tie_to_ls);
    assign grant_if = (state == IDLE) && i_if_req_valid && !grant_ls;

    assign o_ls_req_ready = grant_ls;
    assign o_if_req_ready = grant_if;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            owner_ls        <= 1'b0;
            o_mem_req_valid <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wen       <= 1'b0;
            o_mem_wdata     <= '0;
            o_mem_wmask     <= '0;
            o_if_resp_valid <= 1'b0;
            o_ls_resp_valid <= 1'b0;
            o_if_rdata      <= '0;
            o_ls_rdata      <= '0;
        end else begin
            o_if_resp_valid <= 1'b0;
            o_ls_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // Requester fields are captured here only; the fetch port carries no write data.
                    if (grant_ls || grant_if) begin
                        state           <= REQ;
                        owner_ls        <= grant_ls;
                        o_mem_req_valid <= 1'b1;
                        o_mem_addr      <= grant_ls ? i_ls_addr : i_if_addr;
                        o_mem_wen       <= grant_ls && i_ls_wen;
                        o_mem_wdata     <= grant_ls ? i_ls_wdata : '0;
                        o_mem_wmask     <= grant_ls ? i_ls_wmask : '0;
                    end
                end
                REQ: begin
                    if (i_mem_req_ready) begin
                        state           <= WAIT;
                        o_mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (i_mem_resp_valid) begin
                        state <= IDLE;
                        if (owner_ls) begin
                            o_ls_resp_valid <= 1'b1;
                            o_ls_rdata      <= i_mem_rdata;
                        end else begin
                            o_if_resp_valid <= 1'b1;
                            o_if_rdata      <= i_mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050078_mem_arbiter.sv
// Bench for ysyx_22050078_mem_arbiter: transaction-level model plus directed and random traffic.
module tb_ysyx_22050078_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            if_v, if_rdy, if_rv;
    logic [AW-1:0]   if_addr;
    logic [DW-1:0]   if_rd;
    logic            ls_v, ls_rdy, ls_wen, ls_rv;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata, ls_rd;
    logic [DW/8-1:0] ls_wmask;
    logic            mem_v, mem_rdy, mem_wen, mem_rsp;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [DW/8-1:0] mem_wmask;

    always #5 clk = ~clk;

    ysyx_22050078_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req_valid(if_v), .o_if_req_ready(if_rdy), .i_if_addr(if_addr),
        .o_if_resp_valid(if_rv), .o_if_rdata(if_rd),
        .i_ls_req_valid(ls_v), .o_ls_req_ready(ls_rdy), .i_ls_addr(ls_addr),
        .i_ls_wen(ls_wen), .i_ls_wdata(ls_wdata), .i_ls_wmask(ls_wmask),
        .o_ls_resp_valid(ls_rv), .o_ls_rdata(ls_rd),
        .o_mem_req_valid(mem_v), .i_mem_req_ready(mem_rdy), .o_mem_addr(mem_addr),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_resp_valid(mem_rsp), .i_mem_rdata(mem_rdata)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Transaction-level model: one pending transaction record plus the last-delivered responses.
    logic            m_busy, m_taken, m_owner_ls, m_last_ls;
    logic [AW-1:0]   m_addr;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wmask;
    logic            m_if_rv, m_ls_rv;
    logic [DW-1:0]   m_if_rd, m_ls_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic tie_ls();
`ifdef ARB_ROUND_ROBIN_EN
        return !m_last_ls;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic win_ls();
        return ls_v && (!if_v || tie_ls());
    endfunction

    function automatic logic win_if();
        return if_v && !win_ls();
    endfunction

    task automatic model_reset();
        m_busy = 0; m_taken = 0; m_owner_ls = 0; m_last_ls = 0;
        m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
        m_if_rv = 0; m_ls_rv = 0; m_if_rd = '0; m_ls_rd = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("if_req_ready", if_rdy, !m_busy && win_if());
        chk("ls_req_ready", ls_rdy, !m_busy && win_ls());
        chk("mem_req_valid", mem_v, m_busy && !m_taken);
        if (m_busy && !m_taken) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wen", mem_wen, m_wen);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", mem_wmask, m_wmask);
        end
        chk("if_resp_valid", if_rv, m_if_rv);
        chk("ls_resp_valid", ls_rv, m_ls_rv);
        chk("if_rdata", if_rd, m_if_rd);
        chk("ls_rdata", ls_rd, m_ls_rd);
    endtask

    task automatic advance();
        logic wl, wi;
        wl = win_ls();
        wi = win_if();
        m_if_rv = 0;
        m_ls_rv = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (wl || wi) begin
                m_busy = 1; m_taken = 0; m_owner_ls = wl; m_last_ls = wl;
                m_addr  = wl ? ls_addr : if_addr;
                m_wen   = wl && ls_wen;
                m_wdata = wl ? ls_wdata : '0;
                m_wmask = wl ? ls_wmask : '0;
            end
        end else if (!m_taken) begin
            if (mem_rdy) m_taken = 1;
        end else if (mem_rsp) begin
            m_busy = 0;
            if (m_owner_ls) begin m_ls_rv = 1; m_ls_rd = mem_rdata; end
            else begin m_if_rv = 1; m_if_rd = mem_rdata; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic quiet();
        if_v = 0; ls_v = 0; mem_rsp = 0;
    endtask

    logic [DW-1:0] st_rdata;
    int grants[4];
    int ng;

    initial begin
        rst = 1; if_v = 0; ls_v = 0; mem_rdy = 0; mem_rsp = 0;
        if_addr = '0; ls_addr = '0; ls_wen = 0; ls_wdata = '0; ls_wmask = '0; mem_rdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        rst = 0;

        // Reset state
        sample();
        chk("rst_mem_valid", mem_v, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rd, 0);
        advance();

        // Single fetch, minimum latency
        if_v = 1; if_addr = 64'h8000_0000; mem_rdy = 1;
        sample(); chk("fetch_if_ready", if_rdy, 1); advance();
        if_v = 0; if_addr = 64'hFFFF_0000_1234_5678;
        sample(); chk("fetch_mem_addr", mem_addr, 64'h8000_0000); chk("fetch_mem_wen", mem_wen, 0); advance();
        mem_rsp = 1; mem_rdata = 64'h0000_0413;
        cycle();
        mem_rsp = 0;
        sample();
        chk("fetch_if_rv", if_rv, 1); chk("fetch_if_rdata", if_rd, 64'h413); chk("fetch_ls_rv", ls_rv, 0);
        advance();
        sample(); chk("fetch_pulse_once", if_rv, 0); advance();

        // Store under 5 cycles of memory backpressure
        ls_v = 1; ls_addr = 64'h8000_1000; ls_wen = 1; ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'hFF;
        mem_rdy = 0;
        sample(); chk("store_ls_ready", ls_rdy, 1); advance();
        for (int k = 0; k < 5; k++) begin
            if_v = 1'($urandom); ls_v = 1'($urandom); ls_wen = 1'($urandom);
            ls_addr = {$urandom, $urandom}; ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom);
            if_addr = {$urandom, $urandom};
            sample();
            chk("bp_mem_valid", mem_v, 1);
            chk("bp_mem_addr", mem_addr, 64'h8000_1000);
            chk("bp_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
            chk("bp_mem_wmask", mem_wmask, 8'hFF);
            chk("bp_mem_wen", mem_wen, 1);
            chk("bp_readies", {if_rdy, ls_rdy}, 0);
            advance();
        end
        quiet(); mem_rdy = 1;
        cycle();
        mem_rsp = 1; st_rdata = {$urandom, $urandom}; mem_rdata = st_rdata;
        cycle();
        mem_rsp = 0;
        sample(); chk("store_ls_rv", ls_rv, 1); chk("store_if_rv", if_rv, 0); chk("store_ls_rdata", ls_rd, st_rdata);
        advance();

        // Spurious response while idle
        mem_rsp = 1; mem_rdata = 64'hDEAD;
        cycle();
        sample();
        chk("spur_if_rdata", if_rd, 64'h413); chk("spur_ls_rdata", ls_rd, st_rdata);
        chk("spur_resp", {if_rv, ls_rv}, 0); chk("spur_mem_valid", mem_v, 0);
        mem_rsp = 0;
        advance();

        // Reset while waiting for the memory response
        if_v = 1; if_addr = 64'h8000_0040; mem_rdy = 1;
        cycle();
        if_v = 0;
        cycle();
        rst = 1;
        cycle();
        rst = 0; mem_rsp = 1; mem_rdata = 64'hBAD; if_v = 1; if_addr = 64'h8000_0080;
        sample(); chk("rstw_if_ready", if_rdy, 1); chk("rstw_resp", {if_rv, ls_rv}, 0); advance();
        quiet();
        sample(); chk("rstw_no_resp", {if_rv, ls_rv}, 0); chk("rstw_mem_addr", mem_addr, 64'h8000_0080); advance();
        cycle();
        mem_rsp = 1; cycle();
        quiet(); cycle();

        // Contention: both requesters valid throughout
        rst = 1; cycle(); rst = 0;
        if_v = 1; ls_v = 1; ls_wen = 0; mem_rdy = 1; mem_rsp = 1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            sample();
            if (ls_rdy) begin grants[ng] = 1; ng++; end
            else if (if_rdy) begin grants[ng] = 0; ng++; end
            advance();
        end
        quiet();
        chk("contention_grants_seen", ng, 4);
`ifdef ARB_ROUND_ROBIN_EN
        chk("grant0", grants[0], 1); chk("grant1", grants[1], 0);
        chk("grant2", grants[2], 1); chk("grant3", grants[3], 0);
`else
        chk("grant0", grants[0], 1); chk("grant1", grants[1], 1);
        chk("grant2", grants[2], 1); chk("grant3", grants[3], 1);
`endif
        for (int c = 0; c < 4; c++) cycle();

        // Randomized traffic, including spurious responses and occasional resets
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if_v = 1'($urandom); ls_v = 1'($urandom); ls_wen = 1'($urandom);
            if_addr = {$urandom, $urandom}; ls_addr = {$urandom, $urandom};
            ls_wdata = {$urandom, $urandom}; ls_wmask = 8'($urandom);
            mem_rdy = 1'($urandom); mem_rsp = ($urandom_range(0, 2) == 0);
            mem_rdata = {$urandom, $urandom};
            cycle();
        end
        rst = 0; quiet();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
